// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle control FSM and the shared-memory datapath.
// master = control unit (drives strobes), slave = datapath / IR side.
interface multicycle_control_if;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       BranchNe;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic       LuOp;
    logic [3:0] ALUOp;
    logic       Exception;
    logic [1:0] exc_cause;
    logic [2:0] state;

    modport master (
        input  OpCode, Funct, mem_ready,
        output PCWrite, PCWriteCond, BranchNe, PCSource, IorD, MemRead, MemWrite,
               IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuOp,
               ALUOp, Exception, exc_cause, state
    );

    modport slave (
        output OpCode, Funct, mem_ready,
        input  PCWrite, PCWriteCond, BranchNe, PCSource, IorD, MemRead, MemWrite,
               IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuOp,
               ALUOp, Exception, exc_cause, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/wb sequencing with ready-stretched
// memory states, illegal-instruction and bus-timeout traps.
module multicycle_control #(
    parameter bit          ENABLE_BNE = 1'b1,
    parameter bit          ENABLE_EXC = 1'b1,
    parameter int unsigned STALL_MAX  = 15
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_control_if.master bus
);
    localparam int unsigned CntW = $clog2(STALL_MAX + 1);
    localparam logic [CntW-1:0] StallMaxC = CntW'(STALL_MAX);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        EXC    = 3'd5
    } state_t;

    state_t          state, nextState;
    logic [CntW-1:0] stallCnt;
    logic [1:0]      excCause;
    logic [1:0]      trapCause;

    logic isRType, isJ, isJal, isBranch, isJr, isJalr, isLw, isSw, isShift, isIAlu;
    logic legal, stallLimit;
    logic [2:0] aluOpBase;

    assign isRType  = (bus.OpCode == 6'h00);
    assign isJ      = (bus.OpCode == 6'h02);
    assign isJal    = (bus.OpCode == 6'h03);
    assign isBranch = (bus.OpCode == 6'h04) || (bus.OpCode == 6'h05);
    assign isJr     = isRType && (bus.Funct == 6'h08);
    assign isJalr   = isRType && (bus.Funct == 6'h09);
    assign isLw     = (bus.OpCode == 6'h23);
    assign isSw     = (bus.OpCode == 6'h2B);
    assign isShift  = isRType && (bus.Funct inside {6'h00, 6'h02, 6'h03});
    assign isIAlu   = bus.OpCode inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F};

    // A wait state may only trap once its stall budget is exhausted and ready is still low.
    assign stallLimit = ENABLE_EXC && !bus.mem_ready && (stallCnt == StallMaxC);

    always_comb begin
        legal = 1'b0;
        case (bus.OpCode)
            6'h00:   legal = bus.Funct inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
                                               [6'h20:6'h27], 6'h2A, 6'h2B};
            6'h05:   legal = ENABLE_BNE;
            6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0F, 6'h23, 6'h2B: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        aluOpBase = 3'b000;
        case (bus.OpCode)
            6'h00:        aluOpBase = 3'b010;
            6'h04, 6'h05: aluOpBase = 3'b001;
            6'h0C:        aluOpBase = 3'b100;
            6'h0A, 6'h0B: aluOpBase = 3'b101;
            default:      aluOpBase = 3'b000;
        endcase
    end

    // NOTE: every signal written here gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        nextState       = state;
        trapCause       = 2'b00;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.BranchNe    = 1'b0;
        bus.PCSource    = 2'b00;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 2'b00;
        bus.MemtoReg    = 2'b00;
        bus.ALUSrcA     = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.ExtOp       = 1'b0;
        bus.LuOp        = 1'b0;
        bus.ALUOp       = 4'b0000;
        bus.Exception   = 1'b0;

        // Reset holds every strobe low even though the register already reads FETCH.
        if (!reset) begin
            case (state)
                FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    if (bus.mem_ready) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        nextState   = DECODE;
                    end else if (stallLimit) begin
                        nextState = EXC;
                        trapCause = 2'b10;
                    end
                end
                DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    if (!legal) begin
                        if (ENABLE_EXC) begin
                            nextState = EXC;
                            trapCause = 2'b01;
                        end else begin
                            nextState = FETCH;
                        end
                    end else if (isJ || isJal) begin
                        bus.PCWrite  = 1'b1;
                        bus.PCSource = 2'b10;
                        if (isJal) begin
                            bus.RegWrite = 1'b1;
                            bus.RegDst   = 2'b10;
                            bus.MemtoReg = 2'b10;
                        end
                        nextState = FETCH;
                    end else begin
                        nextState = EXEC;
                    end
                end
                EXEC: begin
                    bus.ALUOp = {bus.OpCode[0], aluOpBase};
                    if (isBranch) begin
                        bus.ALUSrcA     = 2'b01;
                        bus.PCWriteCond = 1'b1;
                        bus.PCSource    = 2'b01;
                        bus.BranchNe    = bus.OpCode[0];
                        nextState       = FETCH;
                    end else if (isJr || isJalr) begin
                        bus.PCWrite  = 1'b1;
                        bus.PCSource = 2'b11;
                        if (isJalr) begin
                            bus.RegWrite = 1'b1;
                            bus.RegDst   = 2'b01;
                            bus.MemtoReg = 2'b10;
                        end
                        nextState = FETCH;
                    end else if (isLw || isSw) begin
                        bus.ALUSrcA = 2'b01;
                        bus.ALUSrcB = 2'b10;
                        nextState   = MEM;
                    end else begin
                        if (isShift) begin
                            bus.ALUSrcA = 2'b10;
                        end else if (isRType) begin
                            bus.ALUSrcA = 2'b01;
                        end else if (isIAlu) begin
                            bus.ALUSrcA = 2'b01;
                            bus.ALUSrcB = 2'b10;
                            bus.ExtOp   = (bus.OpCode != 6'h0C);
                            bus.LuOp    = (bus.OpCode == 6'h0F);
                        end
                        nextState = WB;
                    end
                end
                MEM: begin
                    bus.IorD     = 1'b1;
                    bus.MemRead  = isLw;
                    bus.MemWrite = isSw;
                    if (bus.mem_ready) begin
                        nextState = isLw ? WB : FETCH;
                    end else if (stallLimit) begin
                        nextState = EXC;
                        trapCause = 2'b10;
                    end
                end
                WB: begin
                    bus.RegWrite = 1'b1;
                    if (isLw) begin
                        bus.MemtoReg = 2'b01;
                    end else if (isRType) begin
                        bus.RegDst = 2'b01;
                    end
                    nextState = FETCH;
                end
                EXC: begin
                    bus.Exception = 1'b1;
                    bus.PCWrite   = 1'b1;
                    nextState     = FETCH;
                end
                default: nextState = FETCH;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            stallCnt <= '0;
            excCause <= 2'b00;
        end else begin
            state <= nextState;
            if (trapCause != 2'b00) begin
                excCause <= trapCause;
            end
            // Count only consecutive not-ready cycles within a single FETCH/MEM visit.
            if ((nextState != state) || bus.mem_ready || !((state == FETCH) || (state == MEM))) begin
                stallCnt <= '0;
            end else if (stallCnt != StallMaxC) begin
                stallCnt <= stallCnt + 1'b1;
            end
        end
    end

    assign bus.exc_cause = excCause;
    assign bus.state     = state;
endmodule
